// File: rtl/kf_seq_pkg.sv
// Shared definitions for the kf_microseq instruction sequencer: opcodes,
// FLOW sub-ops, FSM state encoding and instruction field positions.
package kf_seq_pkg;

    // Opcode field c
    localparam logic [1:0] OP_EXEC = 2'b00;
    localparam logic [1:0] OP_WAIT = 2'b01;
    localparam logic [1:0] OP_HALT = 2'b10;
    localparam logic [1:0] OP_FLOW = 2'b11;

    // FLOW sub-op, carried in field d
    localparam logic [1:0] FL_SETCNT = 2'b00;
    localparam logic [1:0] FL_DJNZ   = 2'b01;
    localparam logic [1:0] FL_JMP    = 2'b10;
    localparam logic [1:0] FL_NOP    = 2'b11;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StWait = 2'd2
    } state_e;

    // Fixed low-order field positions
    localparam int unsigned FLD_B_LSB = 6;
    localparam int unsigned FLD_C_LSB = 4;
    localparam int unsigned FLD_D_LSB = 2;
    localparam int unsigned FLD_E_BIT = 1;
    localparam int unsigned FLD_F_BIT = 0;

    // Instruction width for a given address-field width
    function automatic int unsigned iw_of(input int unsigned addrw);
        return 2 * addrw + 6;
    endfunction

    // LSB of field a; field a occupies the top ADDRW bits
    function automatic int unsigned fld_a_lsb(input int unsigned addrw);
        return addrw + 6;
    endfunction

endpackage

// File: rtl/kf_seq_rom.sv
// Microcode store: synchronous write, asynchronous read, no reset.
module kf_seq_rom #(
    parameter int unsigned PCW = 8,
    parameter int unsigned IW  = 16
) (
    input  logic           clk_i,
    input  logic           we_i,
    input  logic [PCW-1:0] waddr_i,
    input  logic [IW-1:0]  wdata_i,
    input  logic [PCW-1:0] raddr_i,
    output logic [IW-1:0]  rdata_o
);

    logic [IW-1:0] mem_q [2**PCW];

    // Write port
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/kf_microseq.sv
// Microcode sequencer: steps a PC through a port-programmable ROM and drives
// Data Bank / AU control fields. Optional WAIT watchdog is enabled by the
// macro KF_SEQ_WATCHDOG_EN; without it wd_err is tied low.
module kf_microseq
    import kf_seq_pkg::*;
#(
    parameter int unsigned ADDRW    = 5,
    parameter int unsigned PCW      = 8,  // must not exceed 2*ADDRW
    parameter int unsigned WD_LIMIT = 1023,
    localparam int unsigned IW      = iw_of(ADDRW)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             START,
    input  logic             ABORT,
    input  logic             au_done,
    input  logic             rom_we,
    input  logic [PCW-1:0]   rom_waddr,
    input  logic [IW-1:0]    rom_wdata,
    output logic             READY,
    output logic             DONE,
    output logic [ADDRW-1:0] fld_a,
    output logic [ADDRW-1:0] fld_b,
    output logic [1:0]       fld_d,
    output logic             au_start,
    output logic             wr_en,
    output logic [PCW-1:0]   pc,
    output logic             wd_err
);

    localparam int unsigned CW = 2 * ADDRW;

    state_e         state_q, state_d;
    logic [PCW-1:0] pc_q, pc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [IW-1:0]  instr;
    logic [1:0]     op, sub;
    logic [CW-1:0]  ab;
    logic           active;

`ifdef KF_SEQ_WATCHDOG_EN
    localparam int unsigned WDW = (WD_LIMIT > 1) ? $clog2(WD_LIMIT) : 1;
    logic [WDW-1:0] wd_cnt_q, wd_cnt_d;
    logic           wd_err_q, wd_err_d;
    assign wd_err = wd_err_q;
`else
    logic unused_wd_limit;
    assign unused_wd_limit = ^WD_LIMIT;
    assign wd_err = 1'b0;
`endif

    assign READY = (state_q == StIdle);

    // Writes only land while idle
    kf_seq_rom #(
        .PCW(PCW),
        .IW (IW)
    ) u_rom (
        .clk_i  (clk),
        .we_i   (rom_we && READY),
        .waddr_i(rom_waddr),
        .wdata_i(rom_wdata),
        .raddr_i(pc_q),
        .rdata_o(instr)
    );

    assign op  = instr[FLD_C_LSB +: 2];
    assign sub = instr[FLD_D_LSB +: 2];
    assign ab  = instr[IW-1:FLD_B_LSB];
    // ABORT blanks the outputs in the same cycle it is seen
    assign active = (state_q != StIdle) && !ABORT;
    assign pc = pc_q;

    // Field decode and output gating
    always_comb begin
        fld_a    = '0;
        fld_b    = '0;
        fld_d    = '0;
        au_start = 1'b0;
        wr_en    = 1'b0;
        if (active) begin
            fld_a    = instr[fld_a_lsb(ADDRW) +: ADDRW];
            fld_b    = instr[FLD_B_LSB +: ADDRW];
            fld_d    = sub;
            au_start = instr[FLD_E_BIT] && (op == OP_EXEC);
            wr_en    = instr[FLD_F_BIT] && ((op == OP_EXEC) || (op == OP_WAIT));
        end
        DONE = (state_q == StRun) && !ABORT && (op == OP_HALT);
    end

    // Next-state, PC and loop counter
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
`ifdef KF_SEQ_WATCHDOG_EN
        wd_cnt_d = wd_cnt_q;
        wd_err_d = wd_err_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (START) begin
                    state_d = StRun;
                    pc_d    = '0;
`ifdef KF_SEQ_WATCHDOG_EN
                    wd_err_d = 1'b0;
`endif
                end
            end
            StRun: begin
                if (ABORT) begin
                    state_d = StIdle;
                end else begin
                    unique case (op)
                        OP_EXEC: pc_d = pc_q + PCW'(1);
                        OP_WAIT: begin
                            if (au_done) begin
                                pc_d = pc_q + PCW'(1);
                            end else begin
                                state_d = StWait;
`ifdef KF_SEQ_WATCHDOG_EN
                                wd_cnt_d = '0;
`endif
                            end
                        end
                        OP_HALT: state_d = StIdle;
                        OP_FLOW: begin
                            unique case (sub)
                                FL_SETCNT: begin
                                    cnt_d = ab;
                                    pc_d  = pc_q + PCW'(1);
                                end
                                FL_DJNZ: begin
                                    if (cnt_q != '0) begin
                                        cnt_d = cnt_q - CW'(1);
                                        pc_d  = ab[PCW-1:0];
                                    end else begin
                                        pc_d = pc_q + PCW'(1);
                                    end
                                end
                                FL_JMP:  pc_d = ab[PCW-1:0];
                                FL_NOP:  pc_d = pc_q + PCW'(1);
                                default: pc_d = pc_q + PCW'(1);
                            endcase
                        end
                        default: state_d = StIdle;
                    endcase
                end
            end
            StWait: begin
                if (ABORT) begin
                    state_d = StIdle;
                end else if (au_done) begin
                    state_d = StRun;
                    pc_d    = pc_q + PCW'(1);
`ifdef KF_SEQ_WATCHDOG_EN
                end else if (wd_cnt_q == WDW'(WD_LIMIT - 1)) begin
                    state_d  = StIdle;
                    wd_err_d = 1'b1;
                end else begin
                    wd_cnt_d = wd_cnt_q + WDW'(1);
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef KF_SEQ_WATCHDOG_EN
    // Watchdog registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_q <= '0;
            wd_err_q <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            wd_err_q <= wd_err_d;
        end
    end
`endif

endmodule

// File: tb/tb_kf_microseq.sv
// Bench for kf_microseq: directed programs plus random programs, every cycle
// compared against an instruction-level interpreter of the sequencer.
module tb_kf_microseq;

    localparam int ADDRW = 5;
    localparam int PCW   = 8;
    localparam int IW    = 16;
    localparam int TB_WD = 8;
    localparam int M_IDLE = 0, M_RUN = 1, M_WAIT = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             START, ABORT, au_done, rom_we;
    logic [PCW-1:0]   rom_waddr;
    logic [IW-1:0]    rom_wdata;
    logic             READY, DONE, au_start, wr_en, wd_err;
    logic [ADDRW-1:0] fld_a, fld_b;
    logic [1:0]       fld_d;
    logic [PCW-1:0]   pc;

    kf_microseq #(
        .ADDRW   (ADDRW),
        .PCW     (PCW),
        .WD_LIMIT(TB_WD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .START    (START),
        .ABORT    (ABORT),
        .au_done  (au_done),
        .rom_we   (rom_we),
        .rom_waddr(rom_waddr),
        .rom_wdata(rom_wdata),
        .READY    (READY),
        .DONE     (DONE),
        .fld_a    (fld_a),
        .fld_b    (fld_b),
        .fld_d    (fld_d),
        .au_start (au_start),
        .wr_en    (wr_en),
        .pc       (pc),
        .wd_err   (wd_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Interpreter state
    logic [15:0] m_rom [256];
    int m_state, m_pc, m_cnt, m_wcnt;
    bit m_wderr;

    // Per-run observations
    int wr_pcs[$];
    int au_pcs[$];
    int n_done, n_pc3;

    function automatic logic [15:0] mk(int a, int b, int c, int d, int e, int f);
        return 16'((a << 11) | (b << 6) | (c << 4) | (d << 2) | (e << 1) | f);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = M_IDLE; m_pc = 0; m_cnt = 0; m_wcnt = 0; m_wderr = 0;
    endtask

    task automatic clear_stats();
        wr_pcs.delete(); au_pcs.delete(); n_done = 0; n_pc3 = 0;
    endtask

    // Outputs implied by the interpreter state and the current ABORT input
    function automatic logic [24:0] exp_outs();
        int ins, op;
        bit act, rdy, dn, st, we;
        ins = int'(m_rom[m_pc]);
        op  = (ins >> 4) & 3;
        act = (m_state != M_IDLE) && !ABORT;
        rdy = (m_state == M_IDLE);
        dn  = (m_state == M_RUN) && !ABORT && (op == 2);
        st  = act && (op == 0) && (((ins >> 1) & 1) == 1);
        we  = act && (op <= 1) && ((ins & 1) == 1);
        if (act)
            return {rdy, dn, st, we, m_wderr, 2'((ins >> 2) & 3), 5'((ins >> 6) & 31),
                    5'((ins >> 11) & 31), 8'(m_pc)};
        return {rdy, dn, 1'b0, 1'b0, m_wderr, 2'b0, 5'b0, 5'b0, 8'(m_pc)};
    endfunction

    // One instruction-level step at a clock edge
    task automatic model_step();
        int ins, op, sub, ab;
        ins = int'(m_rom[m_pc]);
        op  = (ins >> 4) & 3;
        sub = (ins >> 2) & 3;
        ab  = ins >> 6;
        if (m_state == M_IDLE) begin
            if (rom_we) m_rom[rom_waddr] = rom_wdata;
            if (START) begin m_state = M_RUN; m_pc = 0; m_wderr = 0; end
        end else if (ABORT) begin
            m_state = M_IDLE;
        end else if (m_state == M_RUN) begin
            case (op)
                0: m_pc = (m_pc + 1) % 256;
                1: if (au_done) m_pc = (m_pc + 1) % 256;
                   else begin m_state = M_WAIT; m_wcnt = 0; end
                2: m_state = M_IDLE;
                default: begin
                    case (sub)
                        0: begin m_cnt = ab; m_pc = (m_pc + 1) % 256; end
                        1: if (m_cnt != 0) begin m_cnt = m_cnt - 1; m_pc = ab % 256; end
                           else m_pc = (m_pc + 1) % 256;
                        2: m_pc = ab % 256;
                        default: m_pc = (m_pc + 1) % 256;
                    endcase
                end
            endcase
        end else begin
            if (au_done) begin
                m_pc = (m_pc + 1) % 256; m_state = M_RUN;
            end
`ifdef KF_SEQ_WATCHDOG_EN
            else begin
                m_wcnt++;
                if (m_wcnt == TB_WD) begin m_state = M_IDLE; m_wderr = 1; end
            end
`endif
        end
    endtask

    // Compare at the falling edge, then advance DUT and model together
    task automatic cycle();
        logic [24:0] obs;
        @(negedge clk);
        obs = {READY, DONE, au_start, wr_en, wd_err, fld_d, fld_b, fld_a, pc};
        chk("outputs", 64'(obs), 64'(exp_outs()));
        if (wr_en) wr_pcs.push_back(int'(pc));
        if (au_start) au_pcs.push_back(int'(pc));
        if (DONE) n_done++;
        if (!READY && pc == 8'd3) n_pc3++;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic load(input int addr, input logic [15:0] w);
        rom_we = 1'b1; rom_waddr = 8'(addr); rom_wdata = w;
        cycle();
        rom_we = 1'b0;
    endtask

    // Start a program and run it; au_done rises after 'delay' cycles on a WAIT
    task automatic run(input int delay, input int abort_pc, input int abort_after,
                       input int we_pc, input bit rnd, input int budget, input bit must_end);
        int dwell, last_pc, op;
        clear_stats();
        START = 1'b1;
        cycle();
        START = 1'b0;
        dwell = 0; last_pc = -1;
        for (int i = 0; i < budget && m_state != M_IDLE; i++) begin
            dwell = (m_pc == last_pc) ? dwell + 1 : 0;
            last_pc = m_pc;
            op = (int'(m_rom[m_pc]) >> 4) & 3;
            if (rnd) begin
                au_done   = ($urandom_range(0, 2) == 0);
                START     = ($urandom_range(0, 3) == 0);
                rom_we    = ($urandom_range(0, 7) == 0);
                rom_waddr = 8'($urandom);
                rom_wdata = 16'($urandom);
            end else begin
                au_done = (op == 1) && (dwell >= delay);
                rom_we  = (m_pc == we_pc) && (dwell == 2);
                if (rom_we) begin rom_waddr = 8'd0; rom_wdata = 16'hFFFF; end
            end
            ABORT = (m_pc == abort_pc) && (dwell >= abort_after);
            cycle();
        end
        au_done = 1'b0; ABORT = 1'b0; rom_we = 1'b0; START = 1'b0;
        if (must_end) chk("run_ends_ready", 64'(READY), 64'd1);
        else if (m_state != M_IDLE) begin
            ABORT = 1'b1; cycle(); ABORT = 1'b0;
        end
    endtask

    logic [15:0] add_prog [6];
    logic [15:0] loop_prog [4];

    initial begin
        rst_n = 1'b0; START = 0; ABORT = 0; au_done = 0; rom_we = 0;
        rom_waddr = '0; rom_wdata = '0;
        model_reset();
        clear_stats();
        @(posedge clk); #1;
        chk("reset_ready", 64'(READY), 64'd1);
        chk("reset_done", 64'(DONE), 64'd0);
        chk("reset_pc", 64'(pc), 64'd0);
        chk("reset_fields", 64'({fld_a, fld_b, fld_d, au_start, wr_en, wd_err}), 64'd0);
        rst_n = 1'b1;

        // Add program: two bank loads, AU start, wait, write back, halt
        add_prog[0] = mk(0, 0, 0, 0, 0, 1);
        add_prog[1] = mk(1, 0, 0, 0, 0, 1);
        add_prog[2] = mk(0, 1, 0, 1, 1, 0);
        add_prog[3] = mk(0, 0, 1, 0, 0, 0);
        add_prog[4] = mk(2, 0, 0, 2, 0, 1);
        add_prog[5] = mk(0, 0, 2, 0, 0, 0);
        for (int i = 0; i < 6; i++) load(i, add_prog[i]);
        run(4, -1, 0, -1, 0, 40, 1);
        chk("add_wr_count", 64'(wr_pcs.size()), 64'd3);
        if (wr_pcs.size() == 3) begin
            chk("add_wr_pc0", 64'(wr_pcs[0]), 64'd0);
            chk("add_wr_pc1", 64'(wr_pcs[1]), 64'd1);
            chk("add_wr_pc2", 64'(wr_pcs[2]), 64'd4);
        end
        chk("add_au_count", 64'(au_pcs.size()), 64'd1);
        if (au_pcs.size() == 1) chk("add_au_pc", 64'(au_pcs[0]), 64'd2);
        chk("add_done_count", 64'(n_done), 64'd1);
        chk("add_wait_dwell", 64'(n_pc3), 64'd5);
        chk("add_pc_hold", 64'(pc), 64'd5);

        // Stall with au_done low for 10 cycles; a busy-time ROM write is dropped
        run(10, -1, 0, 3, 0, 60, 1);
`ifndef KF_SEQ_WATCHDOG_EN
        chk("stall_dwell", 64'(n_pc3), 64'd11);
        chk("stall_done", 64'(n_done), 64'd1);
`endif
        chk("stall_au_count", 64'(au_pcs.size()), 64'd1);
        chk("rom0_busy_write", 64'(dut.u_rom.mem_q[0]), 64'(add_prog[0]));

        // Abort while in WAIT, then abort on the HALT cycle
        run(10, 3, 3, -1, 0, 60, 1);
        chk("abort_wait_done", 64'(n_done), 64'd0);
        run(0, 5, 0, -1, 0, 60, 1);
        chk("abort_halt_done", 64'(n_done), 64'd0);

        // Idle ROM write lands
        load(0, 16'hFFFF);
        chk("rom0_idle_write", 64'(dut.u_rom.mem_q[0]), 64'hFFFF);

        // Write and START together: first fetched word is the new one
        rom_we = 1'b1; rom_waddr = 8'd0; rom_wdata = mk(0, 0, 2, 0, 0, 0); START = 1'b1;
        cycle();
        rom_we = 1'b0; START = 1'b0;
        chk("we_start_done", 64'(DONE), 64'd1);
        cycle();

        // Loop: SETCNT 3, EXEC f=1, DJNZ ->1, HALT
        loop_prog[0] = mk(0, 3, 3, 0, 0, 0);
        loop_prog[1] = mk(0, 0, 0, 0, 0, 1);
        loop_prog[2] = mk(0, 1, 3, 1, 0, 0);
        loop_prog[3] = mk(0, 0, 2, 0, 0, 0);
        for (int i = 0; i < 4; i++) load(i, loop_prog[i]);
        run(0, -1, 0, -1, 0, 40, 1);
        chk("loop_wr_count", 64'(wr_pcs.size()), 64'd4);
        chk("loop_cnt_end", 64'(dut.cnt_q), 64'd0);
        chk("loop_done_count", 64'(n_done), 64'd1);

        // Asynchronous reset in the middle of a run
        START = 1'b1; cycle(); START = 1'b0;
        cycle(); cycle();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("midrun_rst_outs", 64'({READY, DONE, au_start, wr_en, wd_err, fld_d, fld_b, fld_a, pc}),
            64'(exp_outs()));
        chk("midrun_rst_ready", 64'(READY), 64'd1);
        #1 rst_n = 1'b1;
        cycle();

        // Random programs over the full ROM with random handshakes
        for (int i = 0; i < 256; i++)
            load(i, mk($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 3),
                       $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1)));
        for (int r = 0; r < 8; r++) run(0, -1, 0, -1, 1, 150, 0);

`ifdef KF_SEQ_WATCHDOG_EN
        load(0, mk(0, 0, 1, 0, 0, 0));
        load(1, mk(0, 0, 2, 0, 0, 0));
        run(1000, -1, 0, -1, 0, 30, 1);
        chk("wd_err_set", 64'(wd_err), 64'd1);
        chk("wd_ready", 64'(READY), 64'd1);
        START = 1'b1; cycle(); START = 1'b0;
        chk("wd_err_clear", 64'(wd_err), 64'd0);
        ABORT = 1'b1; cycle(); ABORT = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/kf_microseq.md
Name: kf_microseq

Overview:
- Parametrised successor to the fixed 8-bit-PC instruction sequencer inside the KF top level.
- Holds a port-programmable microcode ROM and steps a PC through it.
- Drives Data Bank address/control fields, AU start and write-enable into the routers, stalls on AU completion, and halts back to READY.
- New versus the current sequencer: width-generic instruction format, loop counter with SETCNT/DJNZ/JMP flow control, abort input, DONE pulse.

Parameters:
- ADDRW, 5, Data Bank address field width; instruction width IW = 2*ADDRW+6.
- PCW, 8, PC width; ROM depth = 2**PCW. Must satisfy PCW <= 2*ADDRW.
- WD_LIMIT, 1023, max WAIT cycles before abort (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- START  in  1  begin execution at PC=0; sampled only while READY=1.
- ABORT  in  1  synchronous abort to IDLE.
- au_done  in  1  AU completion strobe.
- rom_we  in  1  ROM write strobe.
- rom_waddr  in  PCW  ROM write address.
- rom_wdata  in  IW  ROM write data.
- READY  out  1  idle and able to accept START.
- DONE  out  1  one-cycle pulse when HALT retires.
- fld_a  out  ADDRW  instruction field a.
- fld_b  out  ADDRW  instruction field b.
- fld_d  out  2  router/mux select field d.
- au_start  out  1  field e, gated.
- wr_en  out  1  field f, gated.
- pc  out  PCW  current program counter.
- wd_err  out  1  watchdog abort flag; constant 0 if the feature is absent.

Behaviour:
- Instruction format: {a[IW-1:IW-ADDRW], b[next ADDRW], c[5:4], d[3:2], e[1], f[0]}.
- Opcode c: 00 EXEC, 01 WAIT, 10 HALT, 11 FLOW. Under FLOW, d selects: 00 SETCNT, 01 DJNZ, 10 JMP, 11 NOP.
- Reset (async, rst_n=0): state IDLE, pc=0, cnt=0, READY=1, DONE=0, wd_err=0, all field outputs 0. ROM contents are not reset.
- States: IDLE, RUN, WAIT.
- IDLE:
  - START=1 -> pc<=0, RUN next cycle; READY falls that same edge.
  - The first instruction is visible on the outputs in the cycle after START.
- RUN, EXEC: instr = rom[pc] (asynchronous read). fld_a/fld_b/fld_d/au_start/wr_en come combinationally from instr; pc<=pc+1.
- RUN, WAIT: fields are driven, with au_start forced 0.
  - au_done=1 in the same cycle -> pc+1, stay RUN.
  - Otherwise -> WAIT state; pc is held and outputs keep decoding rom[pc].
- WAIT state: au_done=1 -> pc+1, RUN.
- RUN, HALT: DONE=1 this cycle; IDLE next cycle; READY=1 from the next cycle.
- FLOW instructions: au_start=wr_en=0.
  - SETCNT: cnt <= {a,b}, pc+1.
  - DJNZ: if cnt!=0 then cnt<=cnt-1 and pc<={a,b}[PCW-1:0]; else pc+1. SETCNT N followed by body+DJNZ executes the body N+1 times.
  - JMP: pc<={a,b}[PCW-1:0].
- PC at 2**PCW-1 on a non-branch instruction wraps to 0.
- IDLE outputs: fld_*, au_start, wr_en all 0; pc holds its last value.
- ABORT=1 in RUN/WAIT: IDLE next cycle; outputs gated 0 that same cycle; no DONE. ABORT has priority over HALT, START and au_done. ABORT in IDLE has no effect.
- START while not READY: ignored.
- ROM writes:
  - Accepted only when READY=1; dropped otherwise.
  - A write and START in the same cycle: the write lands; execution starts next cycle reading the new word.
- A spurious au_done outside WAIT is ignored.

Optional Feature:
- Macro KF_SEQ_WATCHDOG_EN.
- Defined:
  - A WAIT-cycle counter clears on WAIT entry.
  - When it reaches WD_LIMIT with au_done still 0: state goes to IDLE, wd_err<=1 (sticky until the next START or reset), no DONE.
- Undefined: no counter; WAIT lasts indefinitely; wd_err tied 0.

Decomposition:
- Package kf_seq_pkg: opcode constants (OP_EXEC/OP_WAIT/OP_HALT/OP_FLOW), FLOW sub-op constants, state encoding, field-position functions of ADDRW, IW calculation.
- Sub-module kf_seq_rom: 2**PCW x IW array, synchronous write, asynchronous read.

Test Plan:
- Add program: DB0<=3.0, DB1<=2.5, EXEC e=1, WAIT, write DB2, HALT; au_done after 4 cycles.
  - Required: pc 0..5; au_start pulse only at pc=2; wr_en at pc 0,1,4; DONE one cycle; READY=1 the next cycle.
- Loop: SETCNT 3, EXEC f=1, DJNZ ->1, HALT.
  - Required: wr_en asserted exactly 4 times; cnt ends 0; DONE once.
- WAIT stall: au_done held low 10 cycles.
  - Required: pc constant, au_start=0 throughout; advances the cycle after au_done=1.
- ROM write (addr 0, 16'hFFFF) while busy.
  - Required: rom[0] unchanged after HALT. The same write with READY=1 changes it.
- ABORT during WAIT and during HALT cycle.
  - Required: IDLE next cycle, no DONE, outputs 0.
  - rst_n pulse mid-RUN: all outputs 0 immediately.
- With KF_SEQ_WATCHDOG_EN, WD_LIMIT=8, au_done never asserted.
  - Required: wd_err=1 and READY=1 after 8 WAIT cycles; next START clears wd_err.
